// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the convolution row scheduler: FSM states,
// packet layout and layer geometry.
package conv_sched_pkg;

  localparam int unsigned WIDTH_data     = 8;
  localparam int unsigned WIDTH_addr     = 12;
  localparam int unsigned WIDTH_out_data = 13;
  localparam int unsigned DEPTH_F        = 5;
  localparam int unsigned DEPTH_I        = 25;
  localparam int unsigned DEPTH_R        = DEPTH_I - DEPTH_F + 1;

  localparam int unsigned R_W     = 5;
  localparam int unsigned K_W     = 3;
  localparam int unsigned C_W     = 5;
  localparam int unsigned F_CNT_W = 5;
  localparam int unsigned I_CNT_W = 10;
  localparam int unsigned F_WORDS = DEPTH_F * DEPTH_F;
  localparam int unsigned I_WORDS = DEPTH_I * DEPTH_I;

  localparam logic [1:0] DT_FILTER = 2'd0;
  localparam logic [1:0] DT_IFMAP  = 2'd1;

  localparam int unsigned PKT_DATA_LSB  = 0;
  localparam int unsigned PKT_DEST_LSB  = WIDTH_data;
  localparam int unsigned PKT_DTYPE_LSB = WIDTH_data + K_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_RDWAIT,
    S_SEND,
    S_ROWWAIT
  } state_e;

  typedef struct packed {
    logic [1:0] dtype;
    logic [2:0] dest;
    logic [7:0] data;
  } pkt_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Row/filter-row/column/phase counters for the scheduler, plus the read
// address the next ISSUE will use (derived from the next-state counters).
module conv_addr_gen
  import conv_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  adv_i,
  input  logic                  next_row_i,
  output logic                  phase_o,
  output logic [K_W-1:0]        k_o,
  output logic                  last_word_c,
  output logic                  row_end_c,
  output logic                  r_last_c,
  output logic                  rd_sel_nxt_c,
  output logic [WIDTH_addr-1:0] rd_addr_nxt_c
);

  logic [R_W-1:0] r_q, r_d;
  logic [K_W-1:0] k_q, k_d;
  logic [C_W-1:0] c_q, c_d;
  logic           ph_q, ph_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= '0;
      k_q  <= '0;
      c_q  <= '0;
      ph_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      k_q  <= k_d;
      c_q  <= c_d;
      ph_q <= ph_d;
    end
  end

  // Walk filter row k, then ifmap row r+k, for k = 0..DEPTH_F-1; hold at row end.
  always_comb begin
    r_d  = r_q;
    k_d  = k_q;
    c_d  = c_q;
    ph_d = ph_q;
    if (clr_i) begin
      r_d  = '0;
      k_d  = '0;
      c_d  = '0;
      ph_d = 1'b0;
    end else if (next_row_i) begin
      r_d  = r_q + R_W'(1);
      k_d  = '0;
      c_d  = '0;
      ph_d = 1'b0;
    end else if (adv_i) begin
      if (!ph_q) begin
        if (c_q < C_W'(DEPTH_F - 1)) begin
          c_d = c_q + C_W'(1);
        end else begin
          ph_d = 1'b1;
          c_d  = '0;
        end
      end else if (c_q < C_W'(DEPTH_I - 1)) begin
        c_d = c_q + C_W'(1);
      end else if (k_q < K_W'(DEPTH_F - 1)) begin
        k_d  = k_q + K_W'(1);
        ph_d = 1'b0;
        c_d  = '0;
      end
    end
  end

  always_comb begin
    rd_sel_nxt_c = ph_d;
    if (ph_d) begin
      rd_addr_nxt_c = WIDTH_addr'(r_d + R_W'(k_d)) * WIDTH_addr'(DEPTH_I) + WIDTH_addr'(c_d);
    end else begin
      rd_addr_nxt_c = WIDTH_addr'(k_d) * WIDTH_addr'(DEPTH_F) + WIDTH_addr'(c_d);
    end
  end

  assign phase_o     = ph_q;
  assign k_o         = k_q;
  assign last_word_c = ph_q && (c_q == C_W'(DEPTH_I - 1));
  assign row_end_c   = last_word_c && (k_q == K_W'(DEPTH_F - 1));
  assign r_last_c    = (r_q == R_W'(DEPTH_R - 1));

endmodule

// File: rtl/conv_row_scheduler.sv
// Streams filter and ifmap rows from memory to the row PEs as NoC packets,
// one output row at a time, pacing rows on the output side's row_done token.
module conv_row_scheduler
  import conv_sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      ld_fire,
  input  logic                      ld_sel,
  output logic                      rd_en,
  output logic                      rd_sel,
  output logic [WIDTH_addr-1:0]     rd_addr,
  input  logic [WIDTH_data-1:0]     rd_data,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic [WIDTH_out_data-1:0] pkt_data,
  output logic                      pkt_last,
  input  logic                      row_done,
  output logic                      busy,
  output logic                      done
);

  state_e               state_q, state_d;
  logic [F_CNT_W-1:0]   f_cnt_q, f_cnt_d;
  logic [I_CNT_W-1:0]   i_cnt_q, i_cnt_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 rd_en_q, rd_en_d;
  logic                 rd_sel_q, rd_sel_d;
  logic [WIDTH_addr-1:0] rd_addr_q, rd_addr_d;
  pkt_t                 pkt_q, pkt_d;
  logic                 pkt_valid_q, pkt_valid_d;
  logic                 pkt_last_q, pkt_last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 clr_c, adv_c, next_row_c;
  logic                 phase;
  logic [K_W-1:0]       k;
  logic                 last_word_c, row_end_c, r_last_c, sel_nxt_c;
  logic [WIDTH_addr-1:0] addr_nxt_c;

  conv_addr_gen u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (clr_c),
    .adv_i         (adv_c),
    .next_row_i    (next_row_c),
    .phase_o       (phase),
    .k_o           (k),
    .last_word_c   (last_word_c),
    .row_end_c     (row_end_c),
    .r_last_c      (r_last_c),
    .rd_sel_nxt_c  (sel_nxt_c),
    .rd_addr_nxt_c (addr_nxt_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      f_cnt_q     <= '0;
      i_cnt_q     <= '0;
      rd_pend_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_addr_q   <= '0;
      pkt_q       <= '0;
      pkt_valid_q <= 1'b0;
      pkt_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      f_cnt_q     <= f_cnt_d;
      i_cnt_q     <= i_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_en_q     <= rd_en_d;
      rd_sel_q    <= rd_sel_d;
      rd_addr_q   <= rd_addr_d;
      pkt_q       <= pkt_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_last_q  <= pkt_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state and packet/counter updates; row_done is sticky so an early token is kept.
  always_comb begin
    state_d     = state_q;
    f_cnt_d     = f_cnt_q;
    i_cnt_d     = i_cnt_q;
    rd_pend_d   = rd_pend_q | (row_done && (state_q != S_IDLE));
    pkt_d       = pkt_q;
    pkt_valid_d = pkt_valid_q;
    pkt_last_d  = pkt_last_q;
    done_d      = 1'b0;
    clr_c       = 1'b0;
    adv_c       = 1'b0;
    next_row_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          f_cnt_d   = '0;
          i_cnt_d   = '0;
          rd_pend_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (ld_fire && !ld_sel && (f_cnt_q != F_CNT_W'(F_WORDS))) f_cnt_d = f_cnt_q + F_CNT_W'(1);
        if (ld_fire && ld_sel && (i_cnt_q != I_CNT_W'(I_WORDS))) i_cnt_d = i_cnt_q + I_CNT_W'(1);
        if ((f_cnt_d == F_CNT_W'(F_WORDS)) && (i_cnt_d == I_CNT_W'(I_WORDS))) begin
          state_d = S_ISSUE;
          clr_c   = 1'b1;
        end
      end
      S_ISSUE: state_d = S_RDWAIT;
      S_RDWAIT: begin
        pkt_d.dtype = phase ? DT_IFMAP : DT_FILTER;
        pkt_d.dest  = k;
        pkt_d.data  = rd_data;
        pkt_valid_d = 1'b1;
        pkt_last_d  = last_word_c;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (pkt_valid_q && pkt_ready) begin
          pkt_valid_d = 1'b0;
          pkt_last_d  = 1'b0;
          adv_c       = 1'b1;
          state_d     = row_end_c ? S_ROWWAIT : S_ISSUE;
        end
      end
      S_ROWWAIT: begin
        if (rd_pend_q) begin
          rd_pend_d = 1'b0;
          if (r_last_c) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            next_row_c = 1'b1;
            state_d    = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read strobe/address are registered on entry to ISSUE from the next counter values.
  always_comb begin
    rd_en_d   = (state_d == S_ISSUE);
    rd_sel_d  = rd_en_d ? sel_nxt_c : rd_sel_q;
    rd_addr_d = rd_en_d ? addr_nxt_c : rd_addr_q;
    busy_d    = (state_d != S_IDLE);
  end

  assign rd_en     = rd_en_q;
  assign rd_sel    = rd_sel_q;
  assign rd_addr   = rd_addr_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_data  = pkt_q;
  assign pkt_last  = pkt_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed bench for conv_row_scheduler: load counting, packet order and
// content, backpressure, row_done pacing, done pulse and mid-row reset.
module tb_conv_row_scheduler;
  import conv_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, ld_fire = 1'b0, ld_sel = 1'b0, pkt_ready = 1'b0, row_done = 1'b0;
  logic rd_en, rd_sel, pkt_valid, pkt_last, busy, done;
  logic [WIDTH_addr-1:0]     rd_addr;
  logic [WIDTH_data-1:0]     rd_data = '0;
  logic [WIDTH_out_data-1:0] pkt_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int g_first_rd = 0;
  int g_last_hs = 0;
  int g_last_addr = 0;

  conv_row_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ld_fire   (ld_fire),
    .ld_sel    (ld_sel),
    .rd_en     (rd_en),
    .rd_sel    (rd_sel),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_data  (pkt_data),
    .pkt_last  (pkt_last),
    .row_done  (row_done),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input bit ok, input int obs, input int exp_v);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] mem_val(input logic sel, input logic [WIDTH_addr-1:0] a);
    int v;
    v = sel ? (int'(a) + 90) : ((int'(a) * 3) ^ 195);
    return 8'(v);
  endfunction

  // Synchronous read memory: data appears the cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= mem_val(rd_sel, rd_addr);

  // Word n of output row r: 30 words per filter row k (5 filter, then 25 ifmap).
  task automatic exp_word(input int r, input int n, output int addr, output logic sel,
                          output logic [WIDTH_out_data-1:0] pkt, output logic last);
    int kk, m, c;
    logic [1:0] dt;
    kk = n / 30;
    m  = n % 30;
    if (m < 5) begin
      sel = 1'b0; addr = kk * 5 + m; last = 1'b0; dt = DT_FILTER;
    end else begin
      c = m - 5;
      sel = 1'b1; addr = (r + kk) * 25 + c; last = (c == 24); dt = DT_IFMAP;
    end
    pkt = 13'((int'(dt) << PKT_DTYPE_LSB) | (kk << PKT_DEST_LSB) |
              (int'(mem_val(sel, 12'(addr))) << PKT_DATA_LSB));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int extra_f);
    int early;
    early = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_busy", 32'(busy) === 32'(1'b1), 32'(busy), 1);
    for (int i = 0; i < 25 + extra_f; i++) begin
      ld_fire = 1'b1; ld_sel = 1'b0; step();
      if (rd_en) early++;
    end
    for (int i = 0; i < 624; i++) begin
      ld_fire = 1'b1; ld_sel = 1'b1; step();
      if (rd_en) early++;
      if (i % 100 == 7) begin
        ld_fire = 1'b0; step();
        if (rd_en) early++;
      end
    end
    ld_fire = 1'b0;
    step();
    if (rd_en) early++;
    chk("load_hold_rd", early === 0, early, 0);
    chk("load_hold_busy", 32'(busy) === 32'(1'b1), 32'(busy), 1);
    ld_fire = 1'b1; ld_sel = 1'b1;
    step();
    ld_fire = 1'b0; ld_sel = 1'b0;
    chk("first_rd_en", 32'(rd_en) === 32'(1'b1), 32'(rd_en), 1);
    chk("first_rd_addr", 32'(rd_addr) === 32'(0), 32'(rd_addr), 0);
    chk("first_rd_sel", 32'(rd_sel) === 32'(1'b0), 32'(rd_sel), 0);
  endtask

  // Stream one output row; entry point is the cycle sampled just before its first ISSUE.
  task automatic run_row(input int r, input int stall_at, input int early_at, input int abort_at);
    int hs, nrd, stall_left, budget, nlast, ea, exp_cyc;
    logic es, el;
    logic [WIDTH_out_data-1:0] ep, held;
    bit stalled, early_sent;
    hs = 0; nrd = 0; stall_left = 0; budget = 0; nlast = 0;
    stalled = 1'b0; early_sent = 1'b0; held = '0;
    g_first_rd = -1;
    while (hs < 150 && budget < 1000) begin
      row_done = 1'b0;
      if (abort_at >= 0 && hs == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy) === 32'(1'b0), 32'(busy), 0);
        chk("abort_rd_en", 32'(rd_en) === 32'(1'b0), 32'(rd_en), 0);
        chk("abort_valid", 32'(pkt_valid) === 32'(1'b0), 32'(pkt_valid), 0);
        chk("abort_last", 32'(pkt_last) === 32'(1'b0), 32'(pkt_last), 0);
        chk("abort_addr", 32'(rd_addr) === 32'(0), 32'(rd_addr), 0);
        chk("abort_data", 32'(pkt_data) === 32'(0), 32'(pkt_data), 0);
        return;
      end
      if (!early_sent && early_at >= 0 && hs == early_at) begin
        row_done = 1'b1; early_sent = 1'b1;
      end
      if (rd_en) begin
        exp_word(r, nrd, ea, es, ep, el);
        chk("rd_addr", 32'(rd_addr) === 32'(ea), 32'(rd_addr), ea);
        chk("rd_sel", 32'(rd_sel) === 32'(es), 32'(rd_sel), 32'(es));
        if (nrd == 0) g_first_rd = cyc;
        g_last_addr = int'(rd_addr);
        nrd++;
      end
      pkt_ready = 1'b1;
      if (pkt_valid) begin
        if (hs == stall_at && !stalled) begin
          stalled = 1'b1; held = pkt_data; stall_left = 6; pkt_ready = 1'b0;
        end else if (stall_left > 0) begin
          pkt_ready = 1'b0; stall_left--;
          chk("stall_data", 32'(pkt_data) === 32'(held), 32'(pkt_data), 32'(held));
          chk("stall_rd_en", 32'(rd_en) === 32'(1'b0), 32'(rd_en), 0);
        end else begin
          exp_word(r, hs, ea, es, ep, el);
          chk("pkt_data", 32'(pkt_data) === 32'(ep), 32'(pkt_data), 32'(ep));
          chk("pkt_last", 32'(pkt_last) === 32'(el), 32'(pkt_last), 32'(el));
          if (pkt_last) nlast++;
          g_last_hs = cyc;
          hs++;
        end
      end
      step();
      budget++;
    end
    exp_cyc = 449 + ((stall_at >= 0) ? 7 : 0);
    chk("row_words", hs === 150, hs, 150);
    chk("row_reads", nrd === 150, nrd, 150);
    chk("row_lasts", nlast === 5, nlast, 5);
    chk("row_cycles", (g_last_hs - g_first_rd) === exp_cyc, g_last_hs - g_first_rd, exp_cyc);
  endtask

  // Sit in ROWWAIT a cycle, then release the next row with a row_done pulse.
  task automatic row_gap(input bit poke_start);
    chk("wait_rd_en", 32'(rd_en) === 32'(1'b0), 32'(rd_en), 0);
    chk("wait_valid", 32'(pkt_valid) === 32'(1'b0), 32'(pkt_valid), 0);
    start = poke_start;
    step();
    start = 1'b0;
    chk("wait_rd_en2", 32'(rd_en) === 32'(1'b0), 32'(rd_en), 0);
    chk("wait_busy", 32'(busy) === 32'(1'b1), 32'(busy), 1);
    row_done = 1'b1;
    step();
    row_done = 1'b0;
  endtask

  initial begin
    int prev_hs;
    rst_n = 1'b0;
    repeat (4) begin
      start = 1'($urandom); ld_fire = 1'($urandom); ld_sel = 1'($urandom);
      pkt_ready = 1'($urandom); row_done = 1'($urandom);
      step();
    end
    chk("rst_rd_en", 32'(rd_en) === 32'(1'b0), 32'(rd_en), 0);
    chk("rst_rd_sel", 32'(rd_sel) === 32'(1'b0), 32'(rd_sel), 0);
    chk("rst_rd_addr", 32'(rd_addr) === 32'(0), 32'(rd_addr), 0);
    chk("rst_valid", 32'(pkt_valid) === 32'(1'b0), 32'(pkt_valid), 0);
    chk("rst_data", 32'(pkt_data) === 32'(0), 32'(pkt_data), 0);
    chk("rst_last", 32'(pkt_last) === 32'(1'b0), 32'(pkt_last), 0);
    chk("rst_busy", 32'(busy) === 32'(1'b0), 32'(busy), 0);
    chk("rst_done", 32'(done) === 32'(1'b0), 32'(done), 0);
    start = 1'b0; ld_fire = 1'b0; ld_sel = 1'b0; pkt_ready = 1'b0; row_done = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    chk("idle_busy", 32'(busy) === 32'(1'b0), 32'(busy), 0);

    do_load(2);
    run_row(0, 3, 50, -1);
    prev_hs = g_last_hs;
    run_row(1, -1, -1, -1);
    chk("early_done_gap", (g_first_rd - prev_hs) === 2, g_first_rd - prev_hs, 2);
    for (int r = 2; r < 21; r++) begin
      prev_hs = g_last_hs;
      row_gap(r == 2);
      run_row(r, -1, -1, -1);
      chk("row_gap", (g_first_rd - prev_hs) === 4, g_first_rd - prev_hs, 4);
    end
    chk("last_addr", g_last_addr === 624, g_last_addr, 624);

    row_done = 1'b1;
    step();
    row_done = 1'b0;
    chk("done_early", 32'(done) === 32'(1'b0), 32'(done), 0);
    chk("busy_hold", 32'(busy) === 32'(1'b1), 32'(busy), 1);
    step();
    chk("done_pulse", 32'(done) === 32'(1'b1), 32'(done), 1);
    chk("busy_fall", 32'(busy) === 32'(1'b0), 32'(busy), 0);
    step();
    chk("done_once", 32'(done) === 32'(1'b0), 32'(done), 0);

    do_load(0);
    run_row(0, -1, -1, -1);
    for (int r = 1; r < 10; r++) begin
      row_gap(1'b0);
      run_row(r, -1, -1, -1);
    end
    row_gap(1'b0);
    run_row(10, -1, -1, 40);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_abort_busy", 32'(busy) === 32'(1'b0), 32'(busy), 0);
    chk("post_abort_rd_en", 32'(rd_en) === 32'(1'b0), 32'(rd_en), 0);
    chk("post_abort_valid", 32'(pkt_valid) === 32'(1'b0), 32'(pkt_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
